uart_tx_arbiter: RTL

Shares one uart_tx instance between NUM_REQ byte producers. Requesters are served round-robin, one byte per grant. The block drives the transmitter's send_signal/data_input and sequences each transfer using its busy output. It sits between the requesters and uart_tx; only the arbiter talks to the transmitter.

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte producers, one byte per grant.
// Optional transfer watchdog is compiled in with `define UART_ARB_WATCHDOG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int WDOG_CYCLES = 64,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 active,
  output logic                 err
);

  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;
  localparam state_t AFTER_XFER = (GAP_CYCLES == 0) ? IDLE : GAP;

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || WDOG_CYCLES < 2) begin : g_bad_params
    $error("uart_tx_arbiter: parameter out of range");
  end

  state_t             state;
  logic [NUM_REQ-1:0] valid_q;
  logic [NUM_REQ-1:0] eligible;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     idx;
  logic               found;
  logic [GW-1:0]      gap_cnt;
  logic [7:0]         bytes [NUM_REQ];
  logic               wdog_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign bytes[i] = req_data[8*i +: 8];
  end

  // A request must be seen on two consecutive edges, so a byte dropped in the meantime is never granted.
  assign eligible = valid_q & req_valid;
  assign active   = (state != IDLE);

  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

`ifdef UART_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES);
  logic [WW-1:0] wcnt;
  logic          in_xfer;

  assign in_xfer  = (state == SEND) || (state == WAIT_DONE);
  assign wdog_hit = in_xfer && (wcnt == WW'(WDOG_CYCLES - 1));

  // Counter restarts whenever the FSM enters SEND or WAIT_DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wcnt <= '0;
    else if (!wdog_hit && ((state == SEND && !tx_busy) || (state == WAIT_DONE && tx_busy)))
      wcnt <= wcnt + 1'b1;
    else
      wcnt <= '0;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      valid_q   <= '0;
      ptr       <= IDW'(NUM_REQ - 1);
      req_ready <= '0;
      tx_send   <= 1'b0;
      tx_data   <= '0;
      grant_id  <= '0;
      gap_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      valid_q   <= req_valid;
      req_ready <= '0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found && !tx_busy) begin
            tx_data   <= bytes[winner];
            grant_id  <= winner;
            ptr       <= winner;
            req_ready <= ONE_HOT0 << winner;
            tx_send   <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (tx_busy) begin
            tx_send <= 1'b0;
            state   <= WAIT_DONE;
          end else if (wdog_hit) begin
            tx_send <= 1'b0;
            err     <= 1'b1;
            gap_cnt <= '0;
            state   <= AFTER_XFER;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            gap_cnt <= '0;
            state   <= AFTER_XFER;
          end else if (wdog_hit) begin
            err     <= 1'b1;
            gap_cnt <= '0;
            state   <= AFTER_XFER;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_LAST))
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule
